// File: rtl/bcd_seq_conv.sv
// bcd_seq_conv
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// It processes one input bit per clock. A start/done handshake frames each
// conversion. Out-of-range values saturate to all nines and raise overflow.
//
// Optional feature macro: BCD_BLANK_EN
//   defined   - the blank output marks leading-zero digits
//   undefined - blank is tied to 0 and no blanking logic exists
//
// Parameters:
//   BIN_W   binary input width (4..32)
//   DIGITS  number of BCD output digits (1..10)
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     conversion request, sampled only while idle
//   bin       binary value, captured on the edge that accepts start
//   busy      high while a conversion is in progress
//   done      one-cycle pulse when bcd/overflow/blank have been updated
//   bcd       result, digit k in bits [4k+3:4k], k=0 is the ones digit
//   overflow  last conversion exceeded 10^DIGITS-1
//   blank     leading-zero mask, bit k=1 means digit k is a leading zero
module bcd_seq_conv #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow,
    output logic [DIGITS-1:0]     blank
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [BIN_W-1:0]   bin_shift;
    logic [BCD_W-1:0]   bcd_work;
    logic [BCD_W-1:0]   bcd_adj;
    logic               ovf_sticky;
    logic [CNT_W-1:0]   cnt;
    logic               load;
    logic               step;
    logic               finish;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control decode.
    // The SHIFT state exits when the counter is at its last iteration.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                finish     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Add-3 correction on every working digit of 5 or more, ahead of the shift.
    always_comb begin
        bcd_adj = bcd_work;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_work[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_work[4*k +: 4] + 4'd3;
            end
        end
    end

    // Datapath and result registers.
    // The bit that leaves the top of the corrected BCD word is the overflow
    // evidence, so it is kept in a sticky flag.
    // done is registered so that it rises together with the new results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_shift  <= '0;
            bcd_work   <= '0;
            ovf_sticky <= 1'b0;
            cnt        <= '0;
            bcd        <= '0;
            overflow   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= finish;
            if (load) begin
                bin_shift  <= bin;
                bcd_work   <= '0;
                ovf_sticky <= 1'b0;
                cnt        <= CNT_W'(BIN_W);
            end else if (step) begin
                {bcd_work, bin_shift} <= {bcd_adj[BCD_W-2:0], bin_shift, 1'b0};
                ovf_sticky            <= ovf_sticky | bcd_adj[BCD_W-1];
                cnt                   <= cnt - CNT_W'(1);
            end
            if (finish) begin
                bcd      <= ovf_sticky ? {DIGITS{4'h9}} : bcd_work;
                overflow <= ovf_sticky;
            end
        end
    end

`ifdef BCD_BLANK_EN
    // Reset shows the value zero, so every digit except the ones digit is blank.
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    logic [DIGITS-1:0] blank_next;

    // A digit is blank when it and every digit above it are zero.
    // The ones digit is never blank.
    always_comb begin
        logic all_zero;
        blank_next = '0;
        all_zero   = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            all_zero      = all_zero & (bcd_work[4*k +: 4] == 4'd0);
            blank_next[k] = all_zero;
        end
        if (ovf_sticky) begin
            blank_next = '0;
        end
    end

    // Blank mask register, loaded together with the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank <= BLANK_RST;
        end else if (finish) begin
            blank <= blank_next;
        end
    end
`else
    assign blank = '0;
`endif

endmodule
